// File: rtl/phase_loop_filter.sv
// GPSDO loop filter: outlier rejection, block averaging, shift-gain PI control
// with a clamped DAC output and holdover on loss of PPS.
module phase_loop_filter #(
    parameter logic [23:0] SETPOINT    = 24'd100,
    parameter logic [23:0] MAX_ERR     = 24'd50,
    parameter int          AVG_LOG2    = 2,
    parameter int          KP_SHIFT    = 0,
    parameter int          KI_SHIFT    = 2,
    parameter int          INT_W       = 32,
    parameter int          DAC_W       = 16,
    parameter logic [DAC_W-1:0] DAC_MID = 16'd32768,
    parameter int          TIMEOUT_CYC = 15_000_000
) (
    input  logic             CLK_SYS,
    input  logic             CLK_RST,
    input  logic [23:0]      Measure_Phase,
    input  logic             Measure_Done,
    output logic [DAC_W-1:0] DAC_Code,
    output logic             DAC_Valid,
    output logic             Holdover,
    output logic [7:0]       Reject_Cnt
);
    localparam int ACC_W = 25 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SUM_W = INT_W + 2;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]        LAST_SMP = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0]         TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic signed [INT_W-1:0] INT_MAX  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN  = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] DAC_MAX  = SUM_W'({DAC_W{1'b1}});

    typedef enum logic [2:0] {ACC, MEAN, INTEG, SUM, CLAMP} state_t;

    state_t                    state, state_nxt;
    logic signed [ACC_W-1:0]   acc;
    logic        [CNT_W-1:0]   smp_cnt;
    logic signed [24:0]        mean;
    logic signed [INT_W-1:0]   integ;
    logic signed [SUM_W-1:0]   u_q;
    logic        [TO_W-1:0]    to_cnt;

    logic signed [24:0]        err;
    logic        [24:0]        err_abs;
    logic                      accept, take, blk_done, reject, timeout;
    logic signed [INT_W:0]     integ_sum;
    logic signed [INT_W-1:0]   integ_sat;
    logic signed [SUM_W-1:0]   u_nxt;

    assign err      = $signed({1'b0, Measure_Phase}) - $signed({1'b0, SETPOINT});
    assign err_abs  = err[24] ? 25'(-err) : 25'(err);
    assign accept   = (err_abs <= {1'b0, MAX_ERR});
    assign take     = (state == ACC) && Measure_Done && accept;
    assign blk_done = take && (smp_cnt == LAST_SMP);
    assign reject   = Measure_Done && ((state != ACC) || !accept);
    // A fresh sample always wins over an expiring timeout in the same cycle.
    assign timeout  = (to_cnt == TO_MAX) && !Measure_Done;

    assign integ_sum = (INT_W+1)'(integ) + (INT_W+1)'(mean);
    always_comb begin
        integ_sat = integ_sum[INT_W-1:0];
        if (integ_sum[INT_W] != integ_sum[INT_W-1])
            integ_sat = integ_sum[INT_W] ? INT_MIN : INT_MAX;
    end

    assign u_nxt = $signed(SUM_W'(DAC_MID)) + SUM_W'(mean >>> KP_SHIFT)
                 + SUM_W'(integ >>> KI_SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (blk_done) state_nxt = MEAN;
            MEAN:    state_nxt = INTEG;
            INTEG:   state_nxt = SUM;
            SUM:     state_nxt = CLAMP;
            CLAMP:   state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
        if (timeout) state_nxt = ACC;
    end

    always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
        if (CLK_RST) state <= ACC;
        else         state <= state_nxt;
    end

    always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
        if (CLK_RST) begin
            acc     <= '0;
            smp_cnt <= '0;
        end else if (timeout || state == MEAN) begin
            acc     <= '0;
            smp_cnt <= '0;
        end else if (take) begin
            acc     <= acc + ACC_W'(err);
            smp_cnt <= smp_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
        if (CLK_RST) begin
            mean      <= '0;
            integ     <= '0;
            u_q       <= '0;
            DAC_Code  <= DAC_MID;
            DAC_Valid <= 1'b0;
        end else begin
            DAC_Valid <= 1'b0;
            if (!timeout) begin
                case (state)
                    MEAN:  mean  <= 25'(acc >>> AVG_LOG2);
                    INTEG: integ <= integ_sat;
                    SUM:   u_q   <= u_nxt;
                    CLAMP: begin
                        if (u_q[SUM_W-1])       DAC_Code <= '0;
                        else if (u_q > DAC_MAX) DAC_Code <= '1;
                        else                    DAC_Code <= u_q[DAC_W-1:0];
                        DAC_Valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
        if (CLK_RST) begin
            Reject_Cnt <= '0;
            to_cnt     <= '0;
            Holdover   <= 1'b0;
        end else begin
            if (reject && Reject_Cnt != 8'hFF) Reject_Cnt <= Reject_Cnt + 8'd1;
            if (Measure_Done)          to_cnt <= '0;
            else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (Measure_Done)  Holdover <= 1'b0;
            else if (timeout)  Holdover <= 1'b1;
        end
    end
endmodule
